// File: rtl/imem_stream_loader.sv
// Assembles SYNC/LEN/DATA/CSUM byte frames into big-endian words for the imem write port; write pulses 1 cycle after each 4th byte.
// No backpressure: ready whenever out of reset, one byte per cycle; processor held in reset until a verified image is loaded.
module imem_stream_loader #(
  parameter int          ADDR_W    = 12,
  parameter int          MAX_WORDS = 2048,
  parameter int          BASE_ADDR = 0,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_rx_valid,
  input  logic [7:0]        w_rx_data,
  output logic              w_rx_ready,
  output logic [ADDR_W-1:0] r_mem_addr,
  output logic              r_mem_we,
  output logic [31:0]       r_mem_din,
  output logic              r_proc_rst,
  output logic              r_done,
  output logic              r_err,
  output logic [11:0]       r_wcnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_H,
    S_LEN_L,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic        acc;
  logic        sync_hit;
  logic        wr_word;
  logic        len_bad;
  logic        last_word;
  logic [15:0] len;
  logic [15:0] len_n;
  logic [7:0]  csum;
  logic [1:0]  byte_idx;
  logic [23:0] word_sr;

  assign w_rx_ready = ~w_rst;
  assign acc        = w_rx_valid && w_rx_ready;
  assign len_n      = {len[15:8], w_rx_data};
  assign len_bad    = (len_n == 16'd0) || (len_n > 16'(MAX_WORDS));
  assign last_word  = ({4'd0, r_wcnt} + 16'd1) == len;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sync_hit  = 1'b0;
    wr_word   = 1'b0;
    if (acc) begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_rx_data == SYNC) begin
            state_nxt = S_LEN_H;
            sync_hit  = 1'b1;
          end
        end
        S_LEN_H: state_nxt = S_LEN_L;
        S_LEN_L: state_nxt = len_bad ? S_ERR : S_DATA;
        S_DATA: begin
          if (byte_idx == 2'd3) begin
            wr_word = 1'b1;
            if (last_word) state_nxt = S_CSUM;
          end
        end
        S_CSUM:  state_nxt = (w_rx_data == csum) ? S_DONE : S_ERR;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Status flags follow the next state, so they change on exactly the transition edge.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_mem_addr <= ADDR_W'(BASE_ADDR);
      r_mem_we   <= 1'b0;
      r_mem_din  <= 32'd0;
      r_proc_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_wcnt     <= 12'd0;
      len        <= 16'd0;
      csum       <= 8'd0;
      byte_idx   <= 2'd0;
      word_sr    <= 24'd0;
    end else begin
      r_mem_we   <= wr_word;
      r_proc_rst <= (state_nxt != S_DONE);
      r_done     <= (state_nxt == S_DONE);
      r_err      <= (state_nxt == S_ERR);
      if (sync_hit) begin
        csum     <= 8'd0;
        r_wcnt   <= 12'd0;
        byte_idx <= 2'd0;
      end
      if (acc) begin
        case (state)
          S_LEN_H: begin
            len[15:8] <= w_rx_data;
            csum      <= csum ^ w_rx_data;
          end
          S_LEN_L: begin
            len[7:0] <= w_rx_data;
            csum     <= csum ^ w_rx_data;
            byte_idx <= 2'd0;
          end
          S_DATA: begin
            csum     <= csum ^ w_rx_data;
            byte_idx <= byte_idx + 2'd1;
            word_sr  <= {word_sr[15:0], w_rx_data};
            if (wr_word) begin
              r_mem_din  <= {word_sr, w_rx_data};
              r_mem_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(r_wcnt);
              r_wcnt     <= r_wcnt + 12'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomized frame stimulus against a frame-level model; two instances (base 0 and base 16) share one byte stream.
`timescale 1ns/1ps
module tb_imem_stream_loader;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic        rx_valid;
  logic [7:0]  rx_data;

  logic        rdy0, we0, prst0, done0, err0;
  logic [11:0] addr0, wcnt0;
  logic [31:0] din0;
  logic        rdy16, we16, prst16, done16, err16;
  logic [11:0] addr16, wcnt16;
  logic [31:0] din16;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses0 = 0;
  int pulses16 = 0;
  logic [31:0] frame_words[$];

  always #5 w_clk = ~w_clk;

  imem_stream_loader #(.BASE_ADDR(0)) u_dut0 (
    .w_clk(w_clk), .w_rst(w_rst), .w_rx_valid(rx_valid), .w_rx_data(rx_data),
    .w_rx_ready(rdy0), .r_mem_addr(addr0), .r_mem_we(we0), .r_mem_din(din0),
    .r_proc_rst(prst0), .r_done(done0), .r_err(err0), .r_wcnt(wcnt0)
  );

  imem_stream_loader #(.BASE_ADDR(16)) u_dut16 (
    .w_clk(w_clk), .w_rst(w_rst), .w_rx_valid(rx_valid), .w_rx_data(rx_data),
    .w_rx_ready(rdy16), .r_mem_addr(addr16), .r_mem_we(we16), .r_mem_din(din16),
    .r_proc_rst(prst16), .r_done(done16), .r_err(err16), .r_wcnt(wcnt16)
  );

  always @(posedge w_clk) begin
    if (we0)  pulses0++;
    if (we16) pulses16++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called right after a falling edge; returns right after the falling edge following acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) @(negedge w_clk);
    rx_valid = 1'b1;
    rx_data  = b;
    waited   = 0;
    while (!(rdy0 && rdy16) && waited < 16) begin
      @(negedge w_clk);
      waited++;
    end
    if (!(rdy0 && rdy16)) check("ready_timeout", 32'(rdy0), 32'd1);
    @(posedge w_clk);
    @(negedge w_clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  function automatic int pick_gap(input int lo, input int hi);
    return (hi == 0) ? 0 : int'($urandom_range(hi, lo));
  endfunction

  task automatic run_frame(input logic [15:0] n_field, input bit csum_good,
                           input int gap_lo, input int gap_hi, input bit pre);
    bit          len_ok;
    logic [7:0]  cs;
    logic [31:0] w;
    int          p0, p16, n;
    len_ok = (n_field != 16'd0) && (n_field <= 16'd2048);
    n  = len_ok ? int'(n_field) : 0;
    cs = n_field[15:8] ^ n_field[7:0];
    for (int i = 0; i < n; i++)
      cs = cs ^ frame_words[i][31:24] ^ frame_words[i][23:16] ^ frame_words[i][15:8] ^ frame_words[i][7:0];
    if (pre) begin
      send_byte(8'h00, pick_gap(gap_lo, gap_hi));
      send_byte(8'hFF, pick_gap(gap_lo, gap_hi));
    end
    p0  = pulses0;
    p16 = pulses16;
    send_byte(8'hA5, pick_gap(gap_lo, gap_hi));
    check("sync_proc_rst", 32'(prst0), 32'd1);
    check("sync_done", 32'(done0), 32'd0);
    check("sync_err", 32'(err0), 32'd0);
    check("sync_wcnt", 32'(wcnt0), 32'd0);
    send_byte(n_field[15:8], pick_gap(gap_lo, gap_hi));
    send_byte(n_field[7:0], pick_gap(gap_lo, gap_hi));
    if (!len_ok) begin
      check("len_err", 32'(err0), 32'd1);
      check("len_err_done", 32'(done0), 32'd0);
      check("len_err_proc_rst", 32'(prst0), 32'd1);
      check("len_err_no_writes", 32'(pulses0 - p0), 32'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = frame_words[i];
      for (int j = 0; j < 4; j++) begin
        send_byte(w[31-8*j -: 8], pick_gap(gap_lo, gap_hi));
        if (j == 3) begin
          check("we_pulse", 32'(we0), 32'd1);
          check("addr0", 32'(addr0), 32'(i & 'hfff));
          check("din0", din0, w);
          check("addr16", 32'(addr16), 32'((16 + i) & 'hfff));
          check("din16", din16, w);
          check("wcnt", 32'(wcnt0), 32'(i + 1));
        end else begin
          check("we_idle", 32'(we0), 32'd0);
        end
      end
    end
    check("pre_csum_proc_rst", 32'(prst0), 32'd1);
    check("pre_csum_done", 32'(done0), 32'd0);
    send_byte(csum_good ? cs : (cs ^ 8'h01), pick_gap(gap_lo, gap_hi));
    check("end_done", 32'(done0), 32'(csum_good));
    check("end_err", 32'(err0), 32'(!csum_good));
    check("end_proc_rst0", 32'(prst0), 32'(!csum_good));
    check("end_proc_rst16", 32'(prst16), 32'(!csum_good));
    check("end_wcnt", 32'(wcnt0), 32'(n));
    check("end_we", 32'(we0), 32'd0);
    check("writes0", 32'(pulses0 - p0), 32'(n));
    check("writes16", 32'(pulses16 - p16), 32'(n));
  endtask

  task automatic load_frame1();
    frame_words = {};
    frame_words.push_back(32'h20010005);
    frame_words.push_back(32'h1000FFFF);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(rdy0), 32'd0);
    check({tag, "_we"}, 32'(we0), 32'd0);
    check({tag, "_addr0"}, 32'(addr0), 32'd0);
    check({tag, "_addr16"}, 32'(addr16), 32'd16);
    check({tag, "_din"}, din0, 32'd0);
    check({tag, "_proc_rst"}, 32'(prst0), 32'd1);
    check({tag, "_done"}, 32'(done0), 32'd0);
    check({tag, "_err"}, 32'(err0), 32'd0);
    check({tag, "_wcnt"}, 32'(wcnt0), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, nw;
    logic [7:0] part[6];
    w_rst    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    check_reset_values("reset");
    repeat (3) @(negedge w_clk);
    w_rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(rdy0), 32'd1);

    load_frame1();
    run_frame(16'd2, 1'b1, 0, 0, 1'b1);
    run_frame(16'd2, 1'b0, 0, 0, 1'b0);
    frame_words = {};
    run_frame(16'h0000, 1'b1, 0, 0, 1'b0);
    run_frame(16'h0801, 1'b1, 0, 0, 1'b0);
    load_frame1();
    run_frame(16'd2, 1'b1, 1, 5, 1'b0);
    run_frame(16'd2, 1'b1, 0, 0, 1'b0);

    part = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h10, 8'h00};
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 6; i++) send_byte(part[i], 0);
    check("pre_reset_wcnt", 32'(wcnt0), 32'd1);
    p0 = pulses0;
    #3;
    w_rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    repeat (3) @(negedge w_clk);
    #2;
    w_rst = 1'b0;
    @(negedge w_clk);
    check("no_partial_write", 32'(pulses0 - p0), 32'd0);
    run_frame(16'd2, 1'b1, 0, 0, 1'b0);

    frame_words = {};
    for (int i = 0; i < 2048; i++) frame_words.push_back($urandom);
    run_frame(16'd2048, 1'b1, 0, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      nw = int'($urandom_range(8, 0));
      frame_words = {};
      for (int i = 0; i < nw; i++) frame_words.push_back($urandom);
      run_frame(16'(nw), ($urandom_range(3, 0) != 0), 0, 3, ($urandom_range(1, 0) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
